// File: rtl/alu_seq_ctrl.sv
// Sequencer that steps one request at a time through the ALU's load and execute phases, then returns the 64-bit result.
// Optional feature macro ALU_PERF_CNT_EN adds the perf_ops/perf_busy counters.
module alu_seq_ctrl #(
   parameter int WORD_SIZE = 32,
   parameter int MUL_LAT   = 4,
   parameter int DIV_LAT   = 33
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [4:0]             req_opcode,
   input  logic [WORD_SIZE-1:0]   req_a,
   input  logic [WORD_SIZE-1:0]   req_b,
   output logic [WORD_SIZE-1:0]   alu_y,
   output logic [WORD_SIZE-1:0]   alu_b,
   output logic [4:0]             alu_opcode,
   input  logic [2*WORD_SIZE-1:0] alu_c,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [WORD_SIZE-1:0]   resp_hi,
   output logic [WORD_SIZE-1:0]   resp_lo,
   output logic                   resp_err,
   output logic                   busy
`ifdef ALU_PERF_CNT_EN
   ,
   output logic [31:0]            perf_ops,
   output logic [31:0]            perf_busy
`endif
);

   localparam logic [4:0] OP_MUL  = 5'b00011;
   localparam logic [4:0] OP_DIV  = 5'b00100;
   localparam int         MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int         CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD_Y = 2'd1, EXEC = 2'd2, RESP = 2'd3} state_t;

   state_t               state_r, state_nxt_s;
   logic [4:0]           op_code_r;
   logic [WORD_SIZE-1:0] op_a_r, op_b_r;
   logic [CNT_W-1:0]     cnt_r, lat_s;
   logic                 req_err_s, cnt_zero_s;

   function automatic logic is_legal(input logic [4:0] op);
      return (op[4] == 1'b0) && (op != 5'b00000);
   endfunction

   assign req_err_s  = !is_legal(req_opcode) ||
                       ((req_opcode == OP_DIV) && (req_b == {WORD_SIZE{1'b0}}));
   assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
   assign req_ready  = (state_r == IDLE);
   assign resp_valid = (state_r == RESP);
   assign busy       = (state_r != IDLE);
   assign alu_y      = op_a_r;
   assign alu_b      = op_b_r;
   assign alu_opcode = (state_r == EXEC) ? op_code_r : 5'b00000;

   // EXEC length minus one for the latched opcode
   always_comb begin
      lat_s = {CNT_W{1'b0}};
      if (op_code_r == OP_MUL) begin
         lat_s = CNT_W'(MUL_LAT - 1);
      end else if (op_code_r == OP_DIV) begin
         lat_s = CNT_W'(DIV_LAT - 1);
      end else begin
         lat_s = {CNT_W{1'b0}};
      end
   end

   // next-state decode; faulting requests skip straight to RESP
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               if (req_err_s) begin
                  state_nxt_s = RESP;
               end else begin
                  state_nxt_s = LOAD_Y;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD_Y: state_nxt_s = EXEC;
         EXEC: begin
            if (cnt_zero_s) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = EXEC;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // state, operand latches, latency counter and response registers
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_r   <= IDLE;
         op_code_r <= 5'b00000;
         op_a_r    <= {WORD_SIZE{1'b0}};
         op_b_r    <= {WORD_SIZE{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         resp_hi   <= {WORD_SIZE{1'b0}};
         resp_lo   <= {WORD_SIZE{1'b0}};
         resp_err  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == IDLE) && req_valid) begin
            op_code_r <= req_opcode;
            op_a_r    <= req_a;
            op_b_r    <= req_b;
            if (req_err_s) begin
               resp_hi  <= {WORD_SIZE{1'b0}};
               resp_lo  <= {WORD_SIZE{1'b0}};
               resp_err <= 1'b1;
            end
         end
         if (state_r == LOAD_Y) begin
            cnt_r <= lat_s;
         end else if ((state_r == EXEC) && !cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
         end
         if ((state_r == EXEC) && cnt_zero_s) begin
            resp_hi  <= alu_c[2*WORD_SIZE-1:WORD_SIZE];
            resp_lo  <= alu_c[WORD_SIZE-1:0];
            resp_err <= 1'b0;
         end
      end
   end

`ifdef ALU_PERF_CNT_EN
   // handshake and busy-cycle counters, free-running with wrap
   always_ff @(posedge clk) begin
      if (!clr) begin
         perf_ops  <= 32'd0;
         perf_busy <= 32'd0;
      end else begin
         if (resp_valid && resp_ready) begin
            perf_ops <= perf_ops + 32'd1;
         end
         if (busy) begin
            perf_busy <= perf_busy + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed plan cases plus randomized requests against a transaction-level model.
module tb_alu_seq_ctrl;
   localparam int W       = 32;
   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 33;

   logic          clk = 1'b0;
   logic          clr;
   logic          req_valid, req_ready, resp_valid, resp_ready, resp_err, busy;
   logic [4:0]    req_opcode, alu_opcode;
   logic [W-1:0]  req_a, req_b, alu_y, alu_b, resp_hi, resp_lo;
   logic [2*W-1:0] alu_c;
`ifdef ALU_PERF_CNT_EN
   logic [31:0]   perf_ops, perf_busy;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int exp_ops  = 0;
   int exp_busy = 0;

   alu_seq_ctrl #(.WORD_SIZE(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b),
      .alu_y(alu_y), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_err(resp_err), .busy(busy)
`ifdef ALU_PERF_CNT_EN
      , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
   );

   always #5 clk = ~clk;

   // reference ALU: 0 for opcode 0, distinct arithmetic for every other opcode
   function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
      case (op)
         5'd0:    alu_fn = 64'd0;
         5'd1:    alu_fn = {32'd0, y} + {32'd0, b};
         5'd2:    alu_fn = {32'd0, y - b};
         5'd3:    alu_fn = {32'd0, y} * {32'd0, b};
         5'd4:    alu_fn = (b == 32'd0) ? 64'd0 : {y % b, y / b};
         default: alu_fn = {y ^ b, y + {27'd0, op}};
      endcase
   endfunction

   always_comb alu_c = alu_fn(alu_opcode, alu_y, alu_b);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_perf(input string tag);
`ifdef ALU_PERF_CNT_EN
      chk({tag, "_perf_ops"}, {32'd0, perf_ops}, 64'(exp_ops));
      chk({tag, "_perf_busy"}, {32'd0, perf_busy}, 64'(exp_busy));
`endif
   endtask

   task automatic scramble_inputs();
      req_valid  = 1'($urandom_range(0, 1));
      req_a      = $urandom;
      req_b      = $urandom;
      req_opcode = 5'($urandom_range(0, 31));
   endtask

   // one transaction; called and returns at a negedge with the controller idle
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic        err;
      int          n, rc;
      logic [63:0] exp_c;
      err   = (op == 5'd0) || (op > 5'd15) || ((op == 5'd4) && (b == 32'd0));
      n     = (op == 5'd3) ? MUL_LAT : (op == 5'd4) ? DIV_LAT : 1;
      rc    = err ? 1 : 2 + n;
      exp_c = err ? 64'd0 : alu_fn(op, a, b);
      chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
      resp_ready = 1'($urandom_range(0, 1));
      for (int c = 1; c < rc; c++) begin
         @(negedge clk);
         chk("run_alu_opcode", {59'd0, alu_opcode}, (c >= 2) ? {59'd0, op} : 64'd0);
         chk("run_resp_valid", {63'd0, resp_valid}, 64'd0);
         chk("run_busy", {62'd0, busy, req_ready}, 64'd2);
         chk("run_operands", {alu_y, alu_b}, {a, b});
         scramble_inputs();
         resp_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("resp_valid", {62'd0, resp_valid, req_ready}, 64'd2);
      chk("resp_data", {resp_hi, resp_lo}, exp_c);
      chk("resp_err", {63'd0, resp_err}, {63'd0, err});
      chk("resp_alu_opcode", {59'd0, alu_opcode}, 64'd0);
      req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_opcode = 5'd1;
      resp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid_ready", {62'd0, resp_valid, req_ready}, 64'd2);
         chk("hold_data", {resp_hi, resp_lo}, exp_c);
         chk("hold_err", {63'd0, resp_err}, {63'd0, err});
         req_a = $urandom; req_b = $urandom;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_state", {61'd0, resp_valid, req_ready, busy}, 64'd2);
      chk("post_hs_operands", {alu_y, alu_b}, {a, b});
      req_valid = 1'b0; resp_ready = 1'b0;
      exp_ops++;
      exp_busy += rc + hold;
      chk_perf("op");
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {60'd0, req_ready, resp_valid, busy, resp_err}, 64'd8);
      chk({tag, "_ops"}, {alu_y, alu_b}, 64'd0);
      chk({tag, "_resp"}, {resp_hi, resp_lo}, 64'd0);
      chk({tag, "_alu_opcode"}, {59'd0, alu_opcode}, 64'd0);
      exp_ops = 0; exp_busy = 0;
      chk_perf(tag);
   endtask

   initial begin
      logic saw_resp;
      logic [4:0] rop;
      logic [31:0] rb;
      clr = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      req_opcode = 5'd0; req_a = 32'd0; req_b = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      check_reset_outputs("reset");

      do_op(5'd1, 32'd5, 32'd7, 0);
      do_op(5'd3, 32'h0001_0000, 32'h0001_0000, 0);
      do_op(5'd4, 32'd1234, 32'd0, 0);
      do_op(5'd16, 32'd99, 32'd3, 0);
      do_op(5'd2, 32'd100, 32'd58, 5);
      do_op(5'd4, 32'd1000, 32'd7, 2);

      // abort a divide in its tenth EXEC cycle
      req_valid = 1'b1; req_opcode = 5'd4; req_a = $urandom; req_b = 32'd3;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      chk("abort_pre_opcode", {59'd0, alu_opcode}, 64'd4);
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      check_reset_outputs("abort");
      saw_resp = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1'b1;
      end
      chk("abort_no_resp", {63'd0, saw_resp}, 64'd0);
      exp_busy = 0;
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      check_reset_outputs("reset2");

      do_op(5'd1, 32'd5, 32'd7, 0);
      do_op(5'd4, 32'd77, 32'd5, 0);
      do_op(5'd31, 32'd1, 32'd1, 0);
`ifdef ALU_PERF_CNT_EN
      chk("plan_perf_ops", {32'd0, perf_ops}, 64'd3);
      chk("plan_perf_busy", {32'd0, perf_busy}, 64'd39);
`endif

      for (int i = 0; i < 40; i++) begin
         rop = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) rop = 5'($urandom_range(1, 5));
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         do_op(rop, $urandom, rb, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
